// File: rtl/bambu_slave_initiator_pkg.sv
// Shared types and constants for the Bambu slave-port initiator.
package bambu_slave_initiator_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RUN   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    START,
    RUN,
    RESP
  } state_e;

  // Access watchdog: 1024 cycles, counted 0..1023 in a 10-bit counter.
  localparam int ACCESS_TIMEOUT = 1024;
  localparam int WD_W           = 10;

  // LSB offset of a lane's field inside a packed CHANNELS-wide bus.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/bambu_slave_lane_pack.sv
// Packs the lane-0 request onto the CHANNELS-wide slave buses (upper lanes
// held at zero) and extracts lane-0 read data.
module bambu_slave_lane_pack
  import bambu_slave_initiator_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 7
) (
  input  logic                       oe,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [SIZE_W-1:0]          size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  output logic [CHANNELS-1:0]        S_oe_ram,
  output logic [CHANNELS-1:0]        S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
  output logic [DATA_W-1:0]          rdata0
);

  localparam int A0 = lane_lsb(0, ADDR_W);
  localparam int D0 = lane_lsb(0, DATA_W);
  localparam int Z0 = lane_lsb(0, SIZE_W);

  // Lane 0 carries the request; every other lane stays zero.
  always_comb begin
    S_oe_ram                     = '0;
    S_we_ram                     = '0;
    S_addr_ram                   = '0;
    S_Wdata_ram                  = '0;
    S_data_ram_size              = '0;
    S_oe_ram[0]                  = oe;
    S_we_ram[0]                  = we;
    S_addr_ram[A0 +: ADDR_W]     = addr;
    S_Wdata_ram[D0 +: DATA_W]    = wdata;
    S_data_ram_size[Z0 +: SIZE_W] = size;
    rdata0                       = Sout_Rdata_ram[D0 +: DATA_W];
  end

endmodule

// File: rtl/bambu_slave_initiator.sv
// Host-side initiator for the accelerator slave port and start/done control.
// Optional access/run watchdog: define SLAVE_INIT_TIMEOUT_EN.
module bambu_slave_initiator
  import bambu_slave_initiator_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int SIZE_W   = 7,
  parameter int CYC_W    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_wdata,
  input  logic [SIZE_W-1:0]          cmd_size,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic [CYC_W-1:0]           rsp_cycles,
  output logic                       rsp_err,
  output logic [CHANNELS-1:0]        S_oe_ram,
  output logic [CHANNELS-1:0]        S_we_ram,
  output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
  output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
  output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
  input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
  input  logic [CHANNELS-1:0]        Sout_DataRdy,
  output logic                       start_port,
  input  logic                       done_port
);

  state_e              state_q, state_d;
  logic                oe_q, oe_d, we_q, we_d, start_q, start_d;
  logic                rsp_valid_q, rsp_valid_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CYC_W-1:0]    cnt_q, cnt_d, cycles_q, cycles_d;
  logic [DATA_W-1:0]   rdata0;
  logic                rdy0;
`ifdef SLAVE_INIT_TIMEOUT_EN
  logic [WD_W-1:0]     wd_q, wd_d;
`endif

  // Only lane 0 completion matters; the other lanes are observed but ignored.
  assign rdy0 = Sout_DataRdy[0];
  logic lane_unused;
  assign lane_unused = ^Sout_DataRdy;

  // Reset forces cmd_ready low immediately; it rises as soon as reset drops.
  assign cmd_ready  = (state_q == IDLE) && !reset;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_cycles = cycles_q;
  assign rsp_err    = err_q;
  assign start_port = start_q;

  bambu_slave_lane_pack #(
    .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)
  ) u_pack (
    .oe              (oe_q),
    .we              (we_q),
    .addr            (addr_q),
    .wdata           (wdata_q),
    .size            (size_q),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .rdata0          (rdata0)
  );

  // Next-state and next-output logic for the command sequencer.
  always_comb begin
    state_d     = state_q;
    oe_d        = oe_q;
    we_d        = we_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles_q;
`ifdef SLAVE_INIT_TIMEOUT_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        addr_d   = cmd_addr;
        wdata_d  = cmd_wdata;
        size_d   = cmd_size;
        rdata_d  = '0;
        cycles_d = '0;
        err_d    = 1'b0;
        cnt_d    = '0;
`ifdef SLAVE_INIT_TIMEOUT_EN
        wd_d     = '0;
`endif
        case (op_e'(cmd_op))
          OP_READ:  begin oe_d = 1'b1; state_d = ACCESS; end
          OP_WRITE: begin we_d = 1'b1; state_d = ACCESS; end
          OP_RUN:   begin start_d = 1'b1; state_d = START; end
          default:  begin err_d = 1'b1; rsp_valid_d = 1'b1; state_d = RESP; end
        endcase
      end
      ACCESS: begin
        if (rdy0) begin
          rdata_d     = oe_q ? rdata0 : '0;
          oe_d        = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef SLAVE_INIT_TIMEOUT_EN
        else if (&wd_q) begin
          rdata_d     = '0;
          err_d       = 1'b1;
          oe_d        = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      // done_port is deliberately not sampled here.
      START: begin
        cnt_d   = CYC_W'(1);
        state_d = RUN;
      end
      RUN: begin
        if (done_port) begin
          cycles_d    = cnt_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef SLAVE_INIT_TIMEOUT_EN
        else if (&cnt_q) begin
          cycles_d    = cnt_q;
          err_d       = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`endif
        else if (!(&cnt_q)) begin
          cnt_d = cnt_q + CYC_W'(1);
        end
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; async reset clears everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      cycles_q    <= '0;
`ifdef SLAVE_INIT_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      cycles_q    <= cycles_d;
`ifdef SLAVE_INIT_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_bambu_slave_initiator.sv
// Randomized self-checking bench for bambu_slave_initiator.
module tb_bambu_slave_initiator;

  localparam int CH = 2, AW = 10, DW = 64, SW = 7, CW = 32;

  logic                clock, reset;
  logic                cmd_valid, cmd_ready;
  logic [1:0]          cmd_op;
  logic [AW-1:0]       cmd_addr;
  logic [DW-1:0]       cmd_wdata;
  logic [SW-1:0]       cmd_size;
  logic                rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]       rsp_rdata;
  logic [CW-1:0]       rsp_cycles;
  logic [CH-1:0]       S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [CH*AW-1:0]    S_addr_ram;
  logic [CH*DW-1:0]    S_Wdata_ram, Sout_Rdata_ram;
  logic [CH*SW-1:0]    S_data_ram_size;
  logic                start_port, done_port;

  bambu_slave_initiator #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CYC_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_cycles(rsp_cycles), .rsp_err(rsp_err),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Slave environment: memory, completion latency, stability and lane watch.
  logic [63:0]   slv_mem [int];
  logic [63:0]   ref_mem [int];
  int            rdy_lat, en_cycles, start_cnt;
  bit            stab_bad, lane1_bad;
  logic          exp_oe, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_size;

  always @(negedge clock) begin
    Sout_Rdata_ram  = {$urandom, $urandom, $urandom, $urandom};
    Sout_DataRdy[1] = 1'($urandom_range(0, 1));
    if (start_port) start_cnt++;
    if (S_oe_ram[1] || S_we_ram[1] || S_addr_ram[2*AW-1:AW] != 0 ||
        S_Wdata_ram[2*DW-1:DW] != 0 || S_data_ram_size[2*SW-1:SW] != 0)
      lane1_bad = 1;
    if (S_oe_ram[0] || S_we_ram[0]) begin
      en_cycles++;
      if (S_oe_ram[0] !== exp_oe || S_we_ram[0] !== exp_we || S_addr_ram[AW-1:0] !== exp_addr ||
          S_Wdata_ram[DW-1:0] !== exp_wdata || S_data_ram_size[SW-1:0] !== exp_size)
        stab_bad = 1;
      if (en_cycles == rdy_lat) begin
        Sout_DataRdy[0] = 1'b1;
        if (S_we_ram[0]) slv_mem[int'(S_addr_ram[AW-1:0])] = S_Wdata_ram[DW-1:0];
        else Sout_Rdata_ram[DW-1:0] = slv_mem.exists(int'(S_addr_ram[AW-1:0])) ?
                                      slv_mem[int'(S_addr_ram[AW-1:0])] : 64'h0;
      end else begin
        Sout_DataRdy[0] = 1'b0;
      end
    end else begin
      Sout_DataRdy[0] = 1'($urandom_range(0, 1));
    end
  end

  // Issue one command and check its response against the reference rules.
  // lat: ACCESS cycle in which DataRdy[0] returns (0 = never);
  // dly: RUN cycle (1-based) in which done_port is high.
  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] size, input int lat, input int dly,
                        input bit early_done, input int hold);
    logic [DW-1:0] e_rdata = 0;
    logic [CW-1:0] e_cycles = 0;
    logic          e_err = 0;
    int            e_lat = 0, e_en = 0, e_starts, acc_cyc, k;
    bit            got;
    case (op)
      2'b00: begin
        if (lat == 0) begin e_err = 1; e_lat = 1025; e_en = 1024; end
        else begin
          e_rdata = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 64'h0;
          e_lat = lat + 1; e_en = lat;
        end
      end
      2'b01: begin ref_mem[int'(addr)] = wdata; e_lat = lat + 1; e_en = lat; end
      2'b10: e_cycles = CW'(dly);
      default: begin e_err = 1; e_lat = 1; end
    endcase
    e_starts  = start_cnt + (op == 2'b10 ? 1 : 0);
    exp_oe    = (op == 2'b00);
    exp_we    = (op == 2'b01);
    exp_addr  = addr; exp_wdata = wdata; exp_size = size;
    rdy_lat   = lat; en_cycles = 0; stab_bad = 0;

    @(negedge clock);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size; cmd_valid = 1;
    acc_cyc = cyc;
    @(posedge clock); #1;
    cmd_valid = 0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = {$urandom, $urandom};

    if (op == 2'b10) begin
      got = 0;
      for (k = 0; k < 4 && !got; k++) begin @(negedge clock); got = start_port; end
      chk("start_seen", got, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      done_port = early_done;
      for (int i = 0; i < dly; i++) begin @(posedge clock); #1 done_port = 0; end
      done_port = 1;
    end

    got = 0;
    for (k = 0; k < 1200 && !got; k++) begin @(negedge clock); got = rsp_valid; end
    chk("rsp_seen", got, 1);
    done_port = 0;
    if (op != 2'b10) chk("latency", cyc - acc_cyc, e_lat);
    chk("rdata", rsp_rdata, e_rdata);
    chk("cycles", rsp_cycles, e_cycles);
    chk("err", rsp_err, e_err);
    chk("cmd_ready_resp", cmd_ready, 0);
    chk("en_cycles", en_cycles, e_en);
    chk("lane0_stable", stab_bad, 0);
    chk("start_count", start_cnt, e_starts);

    repeat (hold) @(negedge clock);
    if (hold > 0) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, e_rdata);
      chk("hold_cycles", rsp_cycles, e_cycles);
      chk("hold_err", rsp_err, e_err);
    end
    rsp_ready = 1;
    @(posedge clock); #1 rsp_ready = 0;
    @(negedge clock);
    chk("rsp_drop", rsp_valid, 0);
    chk("ready_back", cmd_ready, 1);
  endtask

  initial begin
    bit got;
    clock = 0; reset = 1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; cmd_size = 0;
    rsp_ready = 0; done_port = 0; Sout_DataRdy = 0; Sout_Rdata_ram = 0;
    rdy_lat = 0; en_cycles = 0; start_cnt = 0; stab_bad = 0; lane1_bad = 0;
    exp_oe = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_size = 0;

    repeat (3) @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_en", {S_oe_ram, S_we_ram}, 0);
    chk("rst_start", start_port, 0);
    chk("rst_addr", S_addr_ram, 0);
    chk("rst_rsp", {rsp_rdata, rsp_err}, 0);
    reset = 0;
    @(negedge clock);
    chk("post_rst_ready", cmd_ready, 1);

    // Directed cases
    do_cmd(2'b01, 10'h010, 64'hDEADBEEF, 7'd32, 3, 0, 0, 0);
    do_cmd(2'b00, 10'h010, 64'h0, 7'd32, 1, 0, 0, 0);
    do_cmd(2'b10, 10'h0, 64'h0, 7'd0, 0, 101, 1, 0);
    do_cmd(2'b11, 10'h3FF, 64'h1234, 7'd8, 0, 0, 0, 5);
    do_cmd(2'b10, 10'h0, 64'h0, 7'd0, 0, 1, 1, 2);

    // Reset in the middle of an access
    exp_oe = 1; exp_we = 0; exp_addr = 10'h020; exp_wdata = 64'h55; exp_size = 7'd64;
    rdy_lat = 0; en_cycles = 0;
    @(negedge clock);
    cmd_op = 2'b00; cmd_addr = 10'h020; cmd_wdata = 64'h55; cmd_size = 7'd64; cmd_valid = 1;
    @(posedge clock); #1 cmd_valid = 0;
    repeat (3) @(negedge clock);
    chk("mid_oe_before", S_oe_ram[0], 1);
    reset = 1; #1;
    chk("mid_en_async", {S_oe_ram, S_we_ram}, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    @(negedge clock); reset = 0;
    @(negedge clock);
    chk("mid_ready_after", cmd_ready, 1);
    chk("mid_no_rsp", rsp_valid, 0);
    chk("mid_en_after", {S_oe_ram, S_we_ram}, 0);

`ifdef SLAVE_INIT_TIMEOUT_EN
    do_cmd(2'b00, 10'h030, 64'h0, 7'd64, 0, 0, 0, 0);
`endif

    // Randomized traffic over a small address set so reads hit earlier writes
    for (int n = 0; n < 40; n++) begin
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [SW-1:0] sz;
      op = 2'($urandom_range(0, 3));
      a  = AW'($urandom_range(0, 3) * 8);
      case ($urandom_range(0, 3))
        0: sz = 7'd8; 1: sz = 7'd16; 2: sz = 7'd32; default: sz = 7'd64;
      endcase
      do_cmd(op, a, {$urandom, $urandom}, sz, $urandom_range(1, 5), $urandom_range(1, 20),
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    got = lane1_bad;
    chk("upper_lanes_zero", got, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bambu_slave_initiator.md
Name: bambu_slave_initiator

Overview:
- Host-side initiator for the accelerator's slave memory port (S_oe_ram/S_we_ram/S_addr_ram/S_Wdata_ram/S_data_ram_size, Sout_Rdata_ram/Sout_DataRdy) and its start_port/done_port run control.
- Accepts a simple command stream: read word, write word, run.
- Performs the slave-port transfers to preload inputs and read back results, pulses start_port, and counts cycles until done_port.
- Sits between the test/host harness and the HLS top `main`, in place of the tied-off slave signals.

Parameters:
- CHANNELS, 2, number of slave lanes in the packed port buses
- ADDR_W, 10, address bits per lane
- DATA_W, 64, data bits per lane
- SIZE_W, 7, access-size bits per lane (size in bits: 8/16/32/64)
- CYC_W, 32, width of the run cycle counter

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  00 read, 01 write, 10 run, 11 reserved
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data, LSB-aligned
- cmd_size  in  SIZE_W  access size in bits
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for write/run)
- rsp_cycles  out  CYC_W  run latency (0 for read/write)
- rsp_err  out  1  reserved op or timeout
- S_oe_ram  out  CHANNELS  per-lane read enable
- S_we_ram  out  CHANNELS  per-lane write enable
- S_addr_ram  out  CHANNELS*ADDR_W  packed lane addresses
- S_Wdata_ram  out  CHANNELS*DATA_W  packed lane write data
- S_data_ram_size  out  CHANNELS*SIZE_W  packed lane sizes
- Sout_Rdata_ram  in  CHANNELS*DATA_W  packed lane read data
- Sout_DataRdy  in  CHANNELS  per-lane completion
- start_port  out  1  one-cycle start pulse to accelerator
- done_port  in  1  accelerator completion

Behaviour:
- Reset: all outputs 0, except cmd_ready 0 during reset and 1 in the first cycle after release. State IDLE, counters 0. Reset mid-transfer drops S_* enables and start_port immediately; an in-flight response is discarded.
- Only lane 0 is used. Lanes 1..CHANNELS-1 are driven 0 at all times.
- IDLE: cmd_ready=1. Handshake cmd_valid&cmd_ready latches op/addr/wdata/size. Next state by op: 00 -> ACCESS, 01 -> ACCESS, 10 -> START, 11 -> RESP with rsp_err=1.
- ACCESS: lane 0 holds oe (read) or we (write), plus addr, wdata and size, registered and stable every cycle, until Sout_DataRdy[0]=1.
  - On that cycle: capture Sout_Rdata_ram[DATA_W-1:0] for reads (writes capture 0), go to RESP, and deassert the enables on the following cycle.
  - Minimum latency: command accept to rsp_valid = 2 cycles when DataRdy returns in the first ACCESS cycle.
- START: start_port=1 for exactly one cycle. Cycle counter loads 1. Go to RUN.
- RUN: counter increments each cycle while done_port=0. On done_port=1, rsp_cycles=counter and go to RESP.
  - done_port already high in the START cycle is ignored; only RUN samples it. Minimum run latency reported = 1.
  - Counter saturates at all-ones; it does not wrap.
- RESP: rsp_valid=1 with rdata/cycles/err stable until rsp_ready. Then go to IDLE; rsp_valid drops the next cycle.
  - cmd_ready=0 in every state other than IDLE: one outstanding command at a time.
- Sout_DataRdy asserted outside ACCESS, or on lanes other than 0, is ignored. done_port outside RUN is ignored.
- Size is passed through unchanged; wdata is not masked by size.

Optional Feature:
- SLAVE_INIT_TIMEOUT_EN defined:
  - A watchdog counter runs in ACCESS (limit 1024 cycles) and in RUN (limit 2^CYC_W-1 cycles).
  - On expiry: drop enables, go to RESP with rsp_err=1; rsp_rdata=0 for access timeouts, rsp_cycles=limit for run timeouts.
- Not defined: ACCESS and RUN wait indefinitely; rsp_err is set only by op 11.

Decomposition:
- Shared package holds:
  - op encodings (OP_READ=2'b00, OP_WRITE=2'b01, OP_RUN=2'b10)
  - state enum (IDLE, ACCESS, START, RUN, RESP)
  - lane-pack helper constants for ADDR_W/DATA_W/SIZE_W offsets
  - the 1024-cycle access timeout constant
- One sub-module is natural: bambu_slave_lane_pack. It is combinational packing of the lane-0 request into the CHANNELS-wide buses with zeroed upper lanes, and extraction of lane-0 read data.

Test Plan:
- Write cmd addr=0x010, wdata=64'hDEADBEEF, size=32; DataRdy[0] after 3 cycles -> we[0] high 3 cycles with stable addr/data; rsp_valid, rdata=0, err=0.
- Read addr=0x010 size=32; slave returns 64'hDEADBEEF with DataRdy in first cycle -> rsp_valid 2 cycles after accept, rdata=64'hDEADBEEF, oe[1]/we[1] never high.
- Run cmd; done_port asserted 100 cycles after the start_port pulse -> exactly one start_port pulse, rsp_cycles=101, err=0; a second command is not accepted before rsp_ready.
- cmd_op=11 -> rsp_err=1, no S_* or start_port activity; rsp held 5 cycles with rsp_ready=0 and remains stable.
- Reset asserted in the middle of ACCESS -> S_oe_ram/S_we_ram go to 0 immediately (async), rsp_valid=0, cmd_ready=1 one cycle after release.
- With SLAVE_INIT_TIMEOUT_EN: read with DataRdy never asserted -> rsp_err=1, rdata=0 after 1024 ACCESS cycles.
